// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
//
// Groups the two handshake bundles of the fetch front-end:
//   imem side : imem_req_o, imem_addr_o (fetch queue -> memory)
//               imem_gnt_i, imem_rvalid_i, imem_rdata_i (memory -> fetch queue)
//   IF/ID side: instr_valid_o, instr_o, pc_o (fetch queue -> IF/ID)
//               instr_ready_i (IF/ID -> fetch queue)
//
// Handshake semantics:
//   imem: a request transfers in a cycle where imem_req_o && imem_gnt_i. While
//         imem_req_o is high without a grant, imem_addr_o is held stable.
//         imem_rvalid_i returns one response per granted request, strictly in
//         request order, no earlier than the cycle after the grant.
//   IF/ID: the head entry transfers in a cycle where instr_valid_o &&
//         instr_ready_i; instr_o/pc_o are stable while valid is high and not
//         accepted (unless a redirect flushes the queue).
//
// Modports: master = fetch_queue, slave = memory + IF/ID stage.
// ----------------------------------------------------------------------------
interface fetch_queue_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front-end feeding the IF/ID register. Owns the fetch PC,
// issues word requests to instruction memory, buffers returned instructions
// with their PC in a DEPTH-entry FIFO and presents the head via valid/ready.
// A redirect flushes the FIFO and marks all in-flight responses for discard.
//
// Ports:
//   clk_i          system clock
//   rst_n          asynchronous active-low reset
//   bus            fetch_queue_if.master (imem req/gnt/rvalid + IF/ID valid/ready)
//   redirect_i     branch taken / flush (highest priority)
//   redirect_pc_i  new fetch PC (low two bits ignored)
//   count_o        FIFO occupancy
//   perf_bubble_o  cycles with ready=1 and valid=0 (optional)
//   perf_drop_o    discarded responses (optional)
//
// Optional feature macro: FETCH_PERF_CNT_EN enables the saturating perf
// counters; without it both perf outputs are tied to zero.
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    fetch_queue_if.master            bus,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              perf_bubble_o,
    output logic [31:0]              perf_drop_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [63:0]   entry_q [DEPTH];

    logic          req;
    logic          grant;
    logic          rv_ok;
    logic          keep;
    logic          pop;
    logic [CW:0]   occ;

    // Credits cover both buffered and in-flight words, so a kept response
    // always finds a free FIFO slot.
    assign occ   = {1'b0, count_q} + {1'b0, outst_q};
    assign req   = rst_n && !redirect_i && (outst_q < CW'(MAX_OUTST))
                   && (occ < (CW+1)'(DEPTH));
    assign grant = req && bus.imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rv_ok = bus.imem_rvalid_i && (outst_q != '0);
    assign keep  = rv_ok && (drop_q == '0) && !redirect_i;
    assign pop   = (count_q != '0) && bus.instr_ready_i && !redirect_i;

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = (count_q != '0);
    assign bus.pc_o          = entry_q[rptr_q][63:32];
    assign bus.instr_o       = entry_q[rptr_q][31:0];
    assign count_o           = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(rv_ok);
        drop_d     = drop_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (redirect_i) begin
            // Everything still in flight (minus this cycle's response) is stale.
            drop_d     = outst_q - CW'(rv_ok);
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            resp_pc_d  = {redirect_pc_i[31:2], 2'b00};
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rv_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wptr_d    = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else if (keep) begin
            entry_q[wptr_q] <= {resp_pc_q, bus.imem_rdata_i};
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q;
    logic [31:0] pdrop_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
            pdrop_q  <= '0;
        end else begin
            if (bus.instr_ready_i && (count_q == '0) && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 32'd1;
            end
            // A response voided by a same-cycle redirect is also a discard.
            if (rv_ok && ((drop_q != '0) || redirect_i) && (pdrop_q != '1)) begin
                pdrop_q <= pdrop_q + 32'd1;
            end
        end
    end

    assign perf_bubble_o = bubble_q;
    assign perf_drop_o   = pdrop_q;
`else
    assign perf_bubble_o = 32'd0;
    assign perf_drop_o   = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Drives fetch_queue with a bench-side in-order memory (queue of granted
// addresses) and a random IF/ID consumer, and compares every cycle against a
// queue-based model of the fetch stream. A few literal expectations pin the
// model on the directed start-up, stall and redirect scenarios.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if bus();
    logic                   redirect_i;
    logic [31:0]            redirect_pc_i;
    logic [$clog2(DEPTH):0] count_o;
    logic [31:0]            perf_bubble_o;
    logic [31:0]            perf_drop_o;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUTST(MAX_OUTST),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .count_o      (count_o),
        .perf_bubble_o(perf_bubble_o),
        .perf_drop_o  (perf_drop_o)
    );

    // ---------------- model / scoreboard state ----------------
    logic [63:0] exp_q[$];      // expected FIFO contents {pc, instr}
    logic [31:0] mem_q[$];      // granted, not yet answered addresses
    logic [31:0] m_fetch_pc, m_resp_pc;
    int          m_outst, m_drop;
    longint      m_bubble, m_pdrop;
    int          spurious_pct;
    int          n_checks, n_fail;

    // sampled DUT outputs of the last cycle, for literal checks
    logic        obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    int          obs_count;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        mem_q.delete();
        m_fetch_pc = RESET_PC;
        m_resp_pc  = RESET_PC;
        m_outst    = 0;
        m_drop     = 0;
        m_bubble   = 0;
        m_pdrop    = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;
        #1;
        check("rst_req",    bus.imem_req_o, 0);
        check("rst_addr",   bus.imem_addr_o, RESET_PC);
        check("rst_valid",  bus.instr_valid_o, 0);
        check("rst_instr",  bus.instr_o, 0);
        check("rst_pc",     bus.pc_o, 0);
        check("rst_count",  count_o, 0);
        check("rst_bubble", perf_bubble_o, 0);
        check("rst_drop",   perf_drop_o, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                         input int gnt_pct, input int rv_pct);
        bit          rv, e_req, e_valid, rv_ok, grant, pop;
        logic [31:0] rdata;
        @(negedge clk);
        rv    = 1'b0;
        rdata = $urandom;
        if (mem_q.size() > 0) begin
            if ($urandom_range(0, 99) < rv_pct) begin
                rv    = 1'b1;
                rdata = imem_word(mem_q.pop_front());
            end
        end else if ($urandom_range(0, 99) < spurious_pct) begin
            rv = 1'b1;
        end
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rdata;
        bus.imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
        bus.instr_ready_i = rdy;
        redirect_i        = redir;
        redirect_pc_i     = rpc;
        #1;
        e_req   = !redir && (m_outst < MAX_OUTST) && (exp_q.size() + m_outst < DEPTH);
        e_valid = (exp_q.size() != 0);
        check("imem_req",    bus.imem_req_o, e_req);
        check("imem_addr",   bus.imem_addr_o, m_fetch_pc);
        check("instr_valid", bus.instr_valid_o, e_valid);
        check("count",       count_o, exp_q.size());
        if (e_valid) begin
            check("head_pc",    bus.pc_o, exp_q[0][63:32]);
            check("head_instr", bus.instr_o, exp_q[0][31:0]);
        end
`ifdef FETCH_PERF_CNT_EN
        check("perf_bubble", perf_bubble_o, m_bubble);
        check("perf_drop",   perf_drop_o, m_pdrop);
`else
        check("perf_bubble", perf_bubble_o, 0);
        check("perf_drop",   perf_drop_o, 0);
`endif
        obs_req   = bus.imem_req_o;
        obs_valid = bus.instr_valid_o;
        obs_addr  = bus.imem_addr_o;
        obs_pc    = bus.pc_o;
        obs_instr = bus.instr_o;
        obs_count = int'(count_o);

        // model advance for the coming edge
        grant = e_req && bus.imem_gnt_i;
        rv_ok = rv && (m_outst > 0);
        pop   = e_valid && rdy;
        if (grant) mem_q.push_back(m_fetch_pc);
        if (rdy && !e_valid) m_bubble++;
        if (redir) begin
            exp_q.delete();
            if (rv_ok) m_pdrop++;
            m_drop     = m_outst - (rv_ok ? 1 : 0);
            m_outst    = m_drop;
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_resp_pc  = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (rv_ok) begin
                if (m_drop > 0) begin
                    m_drop--;
                    m_pdrop++;
                end else begin
                    exp_q.push_back({m_resp_pc, rdata});
                    m_resp_pc += 32'd4;
                end
                m_outst--;
            end
            if (grant) begin
                m_outst++;
                m_fetch_pc += 32'd4;
            end
        end
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(($urandom_range(0, 99) < 3), $urandom, ($urandom_range(0, 99) < 70),
                  60, 50);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        n_checks     = 0;
        n_fail       = 0;
        spurious_pct = 0;
        do_reset();

        // Start-up stream: gnt=1, 1-cycle response latency, ready=1.
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, '0, 1'b1, 100, 100);
            if (c == 0) begin
                check("boot_req0",  obs_req, 1);
                check("boot_addr0", obs_addr, 32'h0);
            end
            if (c == 1) check("boot_addr1", obs_addr, 32'h4);
            if (c == 2) begin
                check("boot_addr2",  obs_addr, 32'h8);
                check("boot_valid2", obs_valid, 1);
                check("boot_pc2",    obs_pc, 32'h0);
            end
            if (c == 3) check("boot_pc3", obs_pc, 32'h4);
        end

        // Stall: FIFO fills to DEPTH and requests stop.
        for (int c = 0; c < 10; c++) cycle(1'b0, '0, 1'b0, 100, 100);
        check("stall_count", obs_count, 4);
        check("stall_req",   obs_req, 0);
        cycle(1'b0, '0, 1'b1, 100, 100);
        check("pop_cycle_req", obs_req, 0);
        cycle(1'b0, '0, 1'b0, 100, 100);
        check("after_pop_req", obs_req, 1);

        // Unaligned redirect target is word-aligned.
        cycle(1'b1, 32'h0000_0103, 1'b1, 100, 100);
        check("redir_req", obs_req, 0);
        cycle(1'b0, '0, 1'b1, 100, 100);
        check("redir_addr", obs_addr, 32'h100);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            cycle(1'b0, '0, 1'b1, 100, 100);
            if (obs_valid) begin
                found = 1'b1;
                check("redir_first_pc", obs_pc, 32'h100);
            end
        end
        if (!found) check("redir_first_valid_timeout", 0, 1);

        // Grant withheld: address held.
        for (int c = 0; c < 3; c++) cycle(1'b0, '0, 1'b1, 0, 100);

        // Random traffic, including spurious responses and back-to-back redirects.
        spurious_pct = 5;
        random_run(3000);
        cycle(1'b1, 32'h0000_2000, 1'b1, 60, 50);
        cycle(1'b1, 32'h0000_3004, 1'b1, 60, 50);
        random_run(500);

        // Reset in the middle of traffic.
        do_reset();
        random_run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake. Returned instructions are buffered with their PC in a DEPTH-entry FIFO and presented to IF/ID via valid/ready. A branch/jump redirect flushes the FIFO and discards in-flight responses, replacing the bare PC mux/PC+4 path.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTST, 2, max in-flight imem requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid, responses in request order
imem_rdata_i  in  32  returned instruction
redirect_i  in  1  branch taken / flush
redirect_pc_i  in  32  new fetch PC
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  head instruction
pc_o  out  32  head PC
instr_ready_i  in  1  IF/ID accepts head (low = stall)
count_o  out  $clog2(DEPTH)+1  FIFO occupancy
perf_bubble_o  out  32  see Optional Feature
perf_drop_o  out  32  see Optional Feature

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_n).
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
- Output reset values: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0, count_o=0, perf_*=0.
- Request condition: imem_req_o=1 iff !redirect_i && outstanding<MAX_OUTST && count+outstanding<DEPTH. imem_addr_o=fetch_pc.
  - req is evaluated combinationally from registered state, so req may assert in the first cycle after reset release.
- req&gnt: fetch_pc+=4 (wraps mod 2^32), outstanding++.
- req&!gnt: req and addr are held stable until gnt.
- imem_rvalid_i: outstanding-- in all cases.
  - If drop>0: drop--, data discarded.
  - Else: push {resp_pc, imem_rdata_i}, resp_pc+=4.
  - The credit rule guarantees the FIFO is never full when a kept response arrives.
- FIFO output: the head is registered storage. instr_valid_o=!empty. A pushed entry is visible the cycle after rvalid, so minimum fetch-to-valid latency is gnt cycle +2.
- Pop: on instr_valid_o&instr_ready_i.
  - Simultaneous push and pop leaves count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- Redirect (priority over everything):
  - FIFO cleared; any same-cycle pop/push is void.
  - imem_req_o forced 0.
  - drop := outstanding - imem_rvalid_i.
  - fetch_pc := resp_pc := {redirect_pc_i[31:2],2'b00}.
  - Fetching resumes the next cycle.
- Back-to-back redirects: each reloads the PC; drop is recomputed each time.
- rvalid with outstanding==0 is a protocol error; the response is ignored and the counters are unchanged.
- Invariants: drop<=outstanding<=MAX_OUTST, count<=DEPTH.
- Reset asserted mid-operation: all state clears immediately; in-flight responses after reset release are counted as errors per the rule above. The memory must be reset together with this block.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: perf_bubble_o counts cycles with instr_ready_i=1 && instr_valid_o=0. perf_drop_o counts discarded responses. Both are 32-bit, saturate at 32'hFFFF_FFFF, and clear on reset.
- Undefined: no counter logic; both ports tied to 0.

Test Plan:
1. Reset release, gnt=1, 1-cycle rvalid latency, ready=1 -> addrs 0x0,0x4,0x8 issued on consecutive cycles; pc_o=0x0 valid two cycles after first gnt, then one instruction per cycle in order.
2. ready=0, DEPTH=4 -> exactly 4 grants (0x0..0xC), req drops, count_o=4; the next request 0x10 issues only in the cycle after the first pop.
3. Two requests in flight (0x8,0xC), redirect_pc_i=0x100 -> both responses dropped (perf_drop_o=2 with macro), FIFO empty, next valid pc_o=0x100.
4. redirect_pc_i=0x103 -> imem_addr_o=0x100, pc_o=0x100.
5. gnt=0 for 3 cycles with req=1 -> imem_addr_o held, no fetch_pc advance; on gnt the address advances by 4.
6. Redirect in the same cycle as rvalid and pop, with outstanding=2 -> that response is discarded, drop=1, count_o=0 next cycle; the following rvalid is also discarded.
